// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and helpers for the bus-attached data memory.
package dmem_pkg;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Wide enough for WAIT_STATES up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } dmem_state_e;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the right-justified bus view and the stored word,
// where byte k of a word always lives in bits [8k+7:8k].
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int BIG_ENDIAN = 1
) (
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wr_bus_i,
    input  logic [31:0] word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wr_word_o,
    output logic [31:0] rd_bus_o,
    output logic        misalign_o
);

    logic [7:0]  lo_b;
    logic [7:0]  hi_b;
    logic [7:0]  sel_b;
    logic [15:0] half_mem;

    always_comb begin
        lo_b       = word_i[{offset_i[1], 1'b0, 3'b000} +: 8];
        hi_b       = word_i[{offset_i[1], 1'b1, 3'b000} +: 8];
        sel_b      = word_i[{offset_i, 3'b000} +: 8];
        // Halfword in storage order {b(k+1), b(k)}.
        half_mem   = (BIG_ENDIAN != 0) ? {wr_bus_i[7:0], wr_bus_i[15:8]} : wr_bus_i[15:0];
        be_o       = 4'b0000;
        wr_word_o  = 32'h0;
        rd_bus_o   = 32'h0;
        misalign_o = 1'b0;
        case (size_i)
            SIZE_BYTE: begin
                be_o      = 4'b0001 << offset_i;
                wr_word_o = {4{wr_bus_i[7:0]}};
                rd_bus_o  = {24'h0, sel_b};
            end
            SIZE_HALF: begin
                if (offset_i[0]) begin
                    misalign_o = 1'b1;
                end else begin
                    be_o      = offset_i[1] ? 4'b1100 : 4'b0011;
                    wr_word_o = {2{half_mem}};
                    rd_bus_o  = (BIG_ENDIAN != 0) ? {16'h0, lo_b, hi_b} : {16'h0, hi_b, lo_b};
                end
            end
            SIZE_WORD: begin
                if (offset_i != 2'b00) begin
                    misalign_o = 1'b1;
                end else begin
                    be_o      = 4'b1111;
                    wr_word_o = (BIG_ENDIAN != 0) ? bswap32(wr_bus_i) : wr_bus_i;
                    rd_bus_o  = (BIG_ENDIAN != 0) ? bswap32(word_i) : word_i;
                end
            end
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory_ext.sv
// Bus-attached data RAM with byte/half/word access, wait states and a
// ready/error handshake on the shared tri-state data bus.
module data_memory_ext
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h2000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0,
    parameter int          BIG_ENDIAN  = 1
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [31:0] data_bus_data,
    input  logic [31:0] data_bus_addr,
    input  logic [1:0]  data_bus_mode,
    input  logic [1:0]  data_bus_size,
    output wire         data_bus_ready,
    output wire         data_bus_error
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_END = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    dmem_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       addr_q;
    logic [1:0]        mode_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              ready_q;
    logic              err_q;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              sel;
    logic              req;
    logic              same;
    logic [31:0]       rel_q;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        be;
    logic [31:0]       wr_word;
    logic [31:0]       rd_bus;
    logic              misalign;
    logic              err_acc;
    logic              do_write;
    logic              unused_rel;

    assign sel  = ({1'b0, data_bus_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, data_bus_addr} < ADDR_END);
    assign req  = sel && (data_bus_mode != MODE_IDLE);
    // Any change to the request (or deselection) abandons the transaction.
    assign same = sel && (data_bus_addr == addr_q) && (data_bus_mode == mode_q)
                      && (data_bus_size == size_q);

    assign rel_q      = addr_q - BASE_ADDR;
    assign idx        = rel_q[IDX_W+1:2];
    assign unused_rel = ^rel_q[31:IDX_W+2];

    dmem_lane_align #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_align (
        .size_i    (size_q),
        .offset_i  (rel_q[1:0]),
        .wr_bus_i  (wdata_q),
        .word_i    (mem[idx]),
        .be_o      (be),
        .wr_word_o (wr_word),
        .rd_bus_o  (rd_bus),
        .misalign_o(misalign)
    );

    assign err_acc  = misalign || (mode_q == MODE_RSVD);
    assign do_write = (state_q == BUSY) && same && (cnt_q == '0)
                      && (mode_q == MODE_WRITE) && !err_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            mode_q  <= MODE_IDLE;
            size_q  <= SIZE_BYTE;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (req) begin
                        addr_q  <= data_bus_addr;
                        mode_q  <= data_bus_mode;
                        size_q  <= data_bus_size;
                        wdata_q <= data_bus_data;
                        cnt_q   <= CNT_W'(WAIT_STATES);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!same) begin
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rdata_q <= (mode_q == MODE_READ && !err_acc) ? rd_bus : 32'h0;
                        err_q   <= err_acc;
                        ready_q <= 1'b1;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (!same) begin
                        ready_q <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is never reset; a write in flight is lost because reset forces IDLE.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    assign data_bus_ready = sel ? ready_q : 1'bz;
    assign data_bus_error = sel ? err_q : 1'bz;
    assign data_bus_data  = (state_q == ACK && mode_q == MODE_READ && sel) ? rdata_q : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_data_memory_ext.sv
// Scoreboard bench: three memories on one shared bus (BE/0ws, LE/0ws, BE/3ws).
module tb_data_memory_ext;
    import dmem_pkg::*;

    typedef struct {
        string       name;
        int          req_cyc;
        int          ws;
        logic        chk_data;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [1:0]  mode;
    logic [1:0]  size;
    logic        drv_en;
    logic [31:0] drv_data;
    wire  [31:0] bus_data;
    wire         bus_ready;
    wire         bus_error;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];
    exp_t mon_e;
    exp_t end_e;
    logic prev_rdy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus_data = drv_en ? drv_data : 32'hzzzz_zzzz;
    // Undriven lines read as ready=0, error=1, data=all ones.
    pulldown (bus_ready);
    pullup (bus_error);
    for (genvar i = 0; i < 32; i++) begin : g_pu
        pullup (bus_data[i]);
    end

    data_memory_ext #(.BASE_ADDR(32'h2000), .DEPTH_WORDS(1024), .WAIT_STATES(0), .BIG_ENDIAN(1)) u_be0 (
        .clk(clk), .reset(reset), .data_bus_data(bus_data), .data_bus_addr(addr),
        .data_bus_mode(mode), .data_bus_size(size), .data_bus_ready(bus_ready), .data_bus_error(bus_error));
    data_memory_ext #(.BASE_ADDR(32'h4000), .DEPTH_WORDS(1024), .WAIT_STATES(0), .BIG_ENDIAN(0)) u_le0 (
        .clk(clk), .reset(reset), .data_bus_data(bus_data), .data_bus_addr(addr),
        .data_bus_mode(mode), .data_bus_size(size), .data_bus_ready(bus_ready), .data_bus_error(bus_error));
    data_memory_ext #(.BASE_ADDR(32'h8000), .DEPTH_WORDS(1024), .WAIT_STATES(3), .BIG_ENDIAN(1)) u_be3 (
        .clk(clk), .reset(reset), .data_bus_data(bus_data), .data_bus_addr(addr),
        .data_bus_mode(mode), .data_bus_size(size), .data_bus_ready(bus_ready), .data_bus_error(bus_error));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per rising ready.
    always @(negedge clk) begin
        if (bus_ready === 1'b1 && prev_rdy !== 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: ready rose at cycle %0d, expected no response", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.req_cyc + 1 + mon_e.ws));
                check({mon_e.name, "_error"}, 32'(bus_error), 32'(mon_e.err));
                if (mon_e.chk_data) check({mon_e.name, "_data"}, bus_data, mon_e.data);
            end
        end
        prev_rdy = bus_ready;
    end

    task automatic access(input logic [31:0] a, input logic [1:0] m, input logic [1:0] s,
                          input logic [31:0] wd, input int ws, input int hold, input logic chk_d,
                          input logic [31:0] ed, input logic ee, input string nm);
        exp_t e;
        @(negedge clk);
        addr     = a;
        mode     = m;
        size     = s;
        drv_en   = (m == MODE_WRITE);
        drv_data = wd;
        e.name     = nm;
        e.req_cyc  = cyc + 1;
        e.ws       = ws;
        e.chk_data = chk_d;
        e.data     = ed;
        e.err      = ee;
        sb.push_back(e);
        for (int j = 1; j <= hold; j++) begin
            @(negedge clk);
            if (j <= ws + 1 && m == MODE_READ) check({nm, "_undriven_before_ready"}, bus_data, 32'hFFFF_FFFF);
            // Changing the bus data after the access shows it is sampled only once.
            if (j == ws + 2) drv_data = ~wd;
        end
        mode   = MODE_IDLE;
        drv_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd,
                      input int ws, input logic ee, input string nm);
        access(a, MODE_WRITE, s, wd, ws, ws + 3, 1'b0, 32'h0, ee, nm);
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] s, input int ws,
                      input logic [31:0] ed, input logic ee, input string nm);
        access(a, MODE_READ, s, 32'h0, ws, ws + 3, 1'b1, ed, ee, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        addr     = 32'h2000;
        mode     = MODE_IDLE;
        size     = SIZE_WORD;
        drv_en   = 1'b0;
        drv_data = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(bus_ready), 32'h0);
        check("reset_error", 32'(bus_error), 32'h0);
        check("reset_data_undriven", bus_data, 32'hFFFF_FFFF);
        @(negedge clk);
        reset = 1'b1;

        wr(32'h2000, SIZE_WORD, 32'h1122_3344, 0, 1'b0, "be_wr_word");
        rd(32'h2000, SIZE_WORD, 0, 32'h1122_3344, 1'b0, "be_rd_word");
        rd(32'h2001, SIZE_BYTE, 0, 32'h0000_0022, 1'b0, "be_rd_byte");
        wr(32'h2004, SIZE_WORD, 32'hAAAA_AAAA, 0, 1'b0, "be_wr_fill");
        wr(32'h2006, SIZE_HALF, 32'h0000_BEEF, 0, 1'b0, "be_wr_half");
        rd(32'h2004, SIZE_WORD, 0, 32'hAAAA_BEEF, 1'b0, "be_rd_after_half");

        wr(32'h4004, SIZE_WORD, 32'hAAAA_AAAA, 0, 1'b0, "le_wr_fill");
        wr(32'h4006, SIZE_HALF, 32'h0000_BEEF, 0, 1'b0, "le_wr_half");
        rd(32'h4004, SIZE_WORD, 0, 32'hBEEF_AAAA, 1'b0, "le_rd_after_half");
        rd(32'h4006, SIZE_HALF, 0, 32'h0000_BEEF, 1'b0, "le_rd_half");
        rd(32'h4007, SIZE_BYTE, 0, 32'h0000_00BE, 1'b0, "le_rd_byte");

        wr(32'h8FFC, SIZE_WORD, 32'hCAFE_F00D, 3, 1'b0, "ws3_wr_last");
        rd(32'h8FFC, SIZE_WORD, 3, 32'hCAFE_F00D, 1'b0, "ws3_rd_last");

        @(negedge clk);
        addr = 32'h9000;
        mode = MODE_READ;
        size = SIZE_WORD;
        repeat (6) @(negedge clk);
        check("desel_ready", 32'(bus_ready), 32'h0);
        check("desel_error_undriven", 32'(bus_error), 32'h1);
        check("desel_data_undriven", bus_data, 32'hFFFF_FFFF);
        mode = MODE_IDLE;
        addr = 32'h2000;
        @(negedge clk);

        wr(32'h2003, SIZE_BYTE, 32'h0000_0055, 0, 1'b0, "be_wr_byte");
        rd(32'h2002, SIZE_WORD, 0, 32'h0, 1'b1, "mis_rd_word");
        wr(32'h2003, SIZE_HALF, 32'h0000_1234, 0, 1'b1, "mis_wr_half");
        rd(32'h2000, SIZE_WORD, 0, 32'h1122_3355, 1'b0, "mis_wr_unchanged");
        rd(32'h2000, 2'b11, 0, 32'h0, 1'b1, "rsvd_size");
        access(32'h2000, MODE_RSVD, SIZE_WORD, 32'h0, 0, 3, 1'b0, 32'h0, 1'b1, "rsvd_mode");

        access(32'h2008, MODE_WRITE, SIZE_WORD, 32'h0000_0005, 0, 10, 1'b0, 32'h0, 1'b0, "held_wr");
        rd(32'h2008, SIZE_WORD, 0, 32'h0000_0005, 1'b0, "held_wr_once");

        wr(32'h8FF8, SIZE_WORD, 32'h1234_5678, 3, 1'b0, "ws3_wr_pre_abort");
        @(negedge clk);
        addr     = 32'h8FF8;
        mode     = MODE_WRITE;
        size     = SIZE_WORD;
        drv_en   = 1'b1;
        drv_data = 32'h0000_0099;
        repeat (2) @(negedge clk);
        mode   = MODE_IDLE;
        drv_en = 1'b0;
        repeat (6) @(negedge clk);
        rd(32'h8FF8, SIZE_WORD, 3, 32'h1234_5678, 1'b0, "abort_no_write");

        wr(32'h8FF4, SIZE_WORD, 32'h0BAD_F00D, 3, 1'b0, "ws3_wr_pre_reset");
        @(negedge clk);
        addr     = 32'h8FF4;
        mode     = MODE_WRITE;
        size     = SIZE_WORD;
        drv_en   = 1'b1;
        drv_data = 32'h0000_DEAD;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("busy_reset_ready", 32'(bus_ready), 32'h0);
        check("busy_reset_error", 32'(bus_error), 32'h0);
        mode   = MODE_IDLE;
        drv_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rd(32'h8FF4, SIZE_WORD, 3, 32'h0BAD_F00D, 1'b0, "reset_drops_write");
        rd(32'h2000, SIZE_WORD, 0, 32'h1122_3355, 1'b0, "be_survives_reset");
        rd(32'h4004, SIZE_WORD, 0, 32'hBEEF_AAAA, 1'b0, "le_survives_reset");
        rd(32'h8FFC, SIZE_WORD, 3, 32'hCAFE_F00D, 1'b0, "ws3_survives_reset");

        repeat (5) @(negedge clk);
        while (sb.size() > 0) begin
            end_e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s_missing: ready never rose, expected one response", end_e.name);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_ext.md
Name: data_memory_ext

Overview:
Parametrised successor to the bus-attached data RAM. It serves word, halfword and byte loads and stores on the shared tri-state data bus, with configurable base address, depth, endianness and wait states. It adds a ready/error handshake so the CPU load/store unit can stall on slow memory and trap on misaligned accesses. It sits on the data bus beside the other memory-mapped slaves.

Parameters:
BASE_ADDR, 32'h2000, first byte address decoded (must be 4-byte aligned)
DEPTH_WORDS, 1024, number of 32-bit words (power of two)
WAIT_STATES, 0, extra cycles inserted before the access completes (0..15)
BIG_ENDIAN, 1, 1 = big-endian bus byte order, 0 = little-endian

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
data_bus_data  inout  32  bus data; write data in, read data out; sub-word data right-justified
data_bus_addr  input  32  byte address
data_bus_mode  input  2  00 idle, 01 read, 10 write, 11 reserved
data_bus_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
data_bus_ready  output  1  access complete; 'z' when address not selected
data_bus_error  output  1  access rejected; valid while ready=1; 'z' when not selected

Behaviour:
- Selected when BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
- Word index = (addr - BASE_ADDR) >> 2; byte offset k = addr[1:0].
- Request = selected and mode != 00.
- Internal storage: byte at offset k lives in mem bits [8k+7:8k], independent of BIG_ENDIAN.
- Let bk be the byte at offset k.
  - BIG_ENDIAN=1: word read = {b0,b1,b2,b3}; half read = {bk,bk+1}.
  - BIG_ENDIAN=0: word read = {b3,b2,b1,b0}; half read = {bk+1,bk}.
  - Byte read = bk in bits [7:0]. Upper bits are zero (no sign extension).
- Writes take data from the low bits of the bus and use the same ordering. Only the addressed lanes are written; other bytes are unchanged.
- Error conditions: half with addr[0]=1, word with addr[1:0]!=0, size 11, or mode 11. On error, memory is untouched, read data is 0, and error=1 in ACK.
- FSM states:
  - IDLE: on request, capture addr/mode/size/write-data, load counter with WAIT_STATES, go to BUSY.
  - BUSY: while counter != 0, decrement. When counter == 0, perform the access at that edge (registered read_result or lane write) and go to ACK.
  - ACK: ready=1 (error per rules). Remains in ACK while the request is held unchanged. Go to IDLE when mode=00, addr deselected, or addr/mode/size changes.
- Latency: request sampled at edge N → ready visible after edge N+1+WAIT_STATES. With WAIT_STATES=0, ready is visible one cycle after the request.
- A held request produces exactly one access. A new access requires returning to IDLE.
- In BUSY, if addr, mode or size changes or the address is deselected, abort to IDLE with no access and no ready.
- Bus drive:
  - data_bus_data is driven only when state=ACK, captured mode=read and currently selected; otherwise 'z'.
  - ready and error are 0 when selected and not in ACK.
- Reset (async, any state): state=IDLE, counter=0, read_result=0, ready=0, error=0. Memory contents are not cleared. A write in flight is dropped.
- Simultaneous reset and request: reset wins; the request is seen at the first edge after reset deasserts.

Decomposition:
- Package dmem_pkg holds:
  - mode encodings: MODE_IDLE, MODE_READ, MODE_WRITE
  - size encodings: SIZE_BYTE, SIZE_HALF, SIZE_WORD
  - FSM state enum: IDLE, BUSY, ACK
  - counter width
- Sub-module dmem_lane_align (combinational) holds byte-lane steering:
  - inputs: size, offset, BIG_ENDIAN, bus write data, stored word
  - outputs: 4-bit byte-enable, aligned write word, extracted read data, misalign flag
- Top level holds the FSM, counter, storage array and tri-state drivers.

Test Plan:
- WAIT_STATES=0, BIG_ENDIAN=1: word write 0x11223344 @0x2000, then word read @0x2000 → 0x11223344, ready high one cycle after each request; byte read @0x2001 → 0x00000022.
- Half write 0xBEEF @0x2006 over word 0xAAAAAAAA @0x2004 → word read @0x2004 returns 0xAAAABEEF (BE); repeat with BIG_ENDIAN=0 → 0xBEEFAAAA.
- WAIT_STATES=3: read @0x2FFC → ready rises exactly 4 cycles after request; data bus stays 'z' before ready; address 0x3000 → ready/error/data stay 'z'.
- Misaligned word read @0x2002 → ready=1, error=1, data 0; half write @0x2003 → error=1, memory unchanged on readback.
- Held write request for 10 cycles with value 0x5 → one write only; mode changed to idle mid-BUSY (WAIT_STATES=3) → no write, no ready.
- Reset asserted in BUSY of a write → state IDLE, ready 0, target word retains its old value; earlier stored data survives reset.
